// File: rtl/clb_cfg_loader.sv
// Serial configuration loader for one CLB: hunts for a 4-bit preamble, shifts in a
// CFG_W-bit frame body plus an even-parity bit, and commits the word only when parity holds.
module clb_cfg_loader #(
    parameter int         CFG_W = 37,
    parameter logic [3:0] PRE   = 4'b0010
) (
    input  logic             K,
    input  logic             RST,
    input  logic             DIN,
    input  logic             CE,
    output logic [CFG_W-1:0] CFG,
    output logic             CFG_VALID,
    output logic             BUSY,
    output logic             ERR
);

    localparam int CNT_W = $clog2(CFG_W + 1);

    // Power-on CLB word, built field by field from MSB: mem, comboption, mux2..6select,
    // o2m*_0, o2m*_1, DQmux1/2, floporlatch.
    localparam logic [36:0] CLB_DEFAULT_37 = {16'h0116, 2'b00, 2'b10, 2'b10, 2'b10,
                                              2'b00, 2'b00, 3'b000, 3'b111, 2'b00, 1'b0};
    localparam logic [CFG_W-1:0] CFG_DEFAULT = CFG_W'(CLB_DEFAULT_37);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_hist;
    logic [CNT_W-1:0]   r_cnt;
    logic [CFG_W-1:0]   r_stage;
    logic [CFG_W-1:0]   r_cfg;
    logic               r_valid;
    logic               r_busy;
    logic               r_err;
    logic [3:0]         w_hist_shift;
    logic               w_par_ok;

    function automatic logic f_even_parity(input logic [CFG_W-1:0] v);
        return ^v;
    endfunction

    assign w_hist_shift = {r_hist[2:0], DIN};
    assign w_par_ok     = ((f_even_parity(r_stage) ^ DIN) == 1'b0);

    assign CFG       = r_cfg;
    assign CFG_VALID = r_valid;
    assign BUSY      = r_busy;
    assign ERR       = r_err;

    // State register.
    always_ff @(posedge K) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; every transition is gated by CE so idle cycles freeze the FSM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (CE && (w_hist_shift == PRE)) begin
                    w_next = ST_DATA;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (CE && (r_cnt == CNT_W'(CFG_W - 1))) begin
                    w_next = ST_PARITY;
                end else begin
                    w_next = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (CE) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_PARITY;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath: preamble history, body staging, bit counter and committed outputs.
    always_ff @(posedge K) begin
        if (RST) begin
            r_hist  <= 4'b1111;
            r_cnt   <= {CNT_W{1'b0}};
            r_stage <= {CFG_W{1'b0}};
            r_cfg   <= CFG_DEFAULT;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_busy  <= (w_next != ST_IDLE);
            if (CE) begin
                case (r_state)
                    ST_IDLE: begin
                        r_hist <= w_hist_shift;
                        r_cnt  <= {CNT_W{1'b0}};
                    end
                    ST_DATA: begin
                        r_stage <= {r_stage[CFG_W-2:0], DIN};
                        // Saturate rather than wrap; the FSM leaves DATA well before this matters.
                        if (r_cnt != CNT_W'(CFG_W)) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end else begin
                            r_cnt <= r_cnt;
                        end
                    end
                    ST_PARITY: begin
                        r_hist <= 4'b1111;
                        if (w_par_ok) begin
                            r_cfg   <= r_stage;
                            r_valid <= 1'b1;
                            r_err   <= 1'b0;
                        end else begin
                            r_err   <= 1'b1;
                        end
                    end
                    default: begin
                        r_hist <= 4'b1111;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Randomized self-checking bench for clb_cfg_loader against a frame-level reference model.
module tb_clb_cfg_loader;

    logic        K;
    logic        RST;
    logic        DIN;
    logic        CE;
    logic [36:0] CFG;
    logic        CFG_VALID;
    logic        BUSY;
    logic        ERR;

    int n_cmp;
    int n_bad;

    logic [36:0] m_cfg;
    logic        m_err;

    bit f_busy_drop;
    bit f_cfg_move;
    bit f_early_valid;

    clb_cfg_loader #(.CFG_W(37), .PRE(4'b0010)) dut (
        .K(K), .RST(RST), .DIN(DIN), .CE(CE),
        .CFG(CFG), .CFG_VALID(CFG_VALID), .BUSY(BUSY), .ERR(ERR)
    );

    initial K = 1'b0;
    always #5 K = ~K;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    function automatic logic [36:0] clb_default();
        logic [15:0] mem;
        mem = 16'h0116;
        return {mem, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000, 3'b111, 2'b00, 1'b0};
    endfunction

    task automatic tick(input logic d, input logic ce, input logic rst);
        @(negedge K);
        DIN = d;
        CE  = ce;
        RST = rst;
        @(posedge K);
        #1;
    endtask

    task automatic body_watch();
        if (BUSY !== 1'b1) f_busy_drop = 1'b1;
        if (CFG !== m_cfg) f_cfg_move = 1'b1;
        if (CFG_VALID !== 1'b0) f_early_valid = 1'b1;
    endtask

    // Sends 1111 + 0010 + first nbits of data (MSB first); parity only if nbits == 37.
    task automatic send_frame(input logic [36:0] data, input logic par, input bit gaps, input int nbits);
        logic [7:0] hdr;
        hdr = 8'b1111_0010;
        f_busy_drop = 1'b0;
        f_cfg_move = 1'b0;
        f_early_valid = 1'b0;
        for (int i = 7; i >= 0; i--) tick(hdr[i], 1'b1, 1'b0);
        body_watch();
        for (int i = 36; i >= 37 - nbits; i--) begin
            if (gaps) begin
                tick(1'($urandom_range(1, 0)), 1'b0, 1'b0);
                body_watch();
            end
            tick(data[i], 1'b1, 1'b0);
            body_watch();
        end
        if (nbits == 37) begin
            if (gaps) begin
                tick(~par, 1'b0, 1'b0);
                body_watch();
            end
            tick(par, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; CE = 1'b1; DIN = 1'b1;
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        m_cfg = clb_default();
        m_err = 1'b0;
        n_cmp++; if (CFG !== m_cfg) begin n_bad++; $display("FAIL reset_cfg: got %h want %h", CFG, m_cfg); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_cmp++; if (ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", ERR); end
        n_cmp++; if (CFG_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", CFG_VALID); end
        tick(1'b0, 1'b0, 1'b0);
    endtask

    // Applies one full frame and checks commit/reject behaviour against the model.
    task automatic frame_and_check(input string nm, input logic [36:0] data, input bit bad, input bit gaps);
        logic par;
        logic good;
        par  = ($countones(data) % 2 == 1) ? 1'b1 : 1'b0;
        par  = bad ? ~par : par;
        good = !bad;
        send_frame(data, par, gaps, 37);
        n_cmp++; if (f_busy_drop) begin n_bad++; $display("FAIL %s_busy_body: got BUSY low want high", nm); end
        n_cmp++; if (f_cfg_move) begin n_bad++; $display("FAIL %s_cfg_stable: got CFG change want held %h", nm, m_cfg); end
        n_cmp++; if (f_early_valid) begin n_bad++; $display("FAIL %s_early_valid: got pulse want none", nm); end
        if (good) begin
            m_cfg = data;
            m_err = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        n_cmp++; if (CFG_VALID !== good) begin n_bad++; $display("FAIL %s_valid: got %b want %b", nm, CFG_VALID, good); end
        n_cmp++; if (CFG !== m_cfg) begin n_bad++; $display("FAIL %s_cfg: got %h want %h", nm, CFG, m_cfg); end
        n_cmp++; if (ERR !== m_err) begin n_bad++; $display("FAIL %s_err: got %b want %b", nm, ERR, m_err); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL %s_busy_end: got %b want 0", nm, BUSY); end
        tick(1'b0, 1'b0, 1'b0);
        n_cmp++; if (CFG_VALID !== 1'b0) begin n_bad++; $display("FAIL %s_valid_pulse: got %b want 0", nm, CFG_VALID); end
        n_cmp++; if (CFG !== m_cfg) begin n_bad++; $display("FAIL %s_cfg_hold: got %h want %h", nm, CFG, m_cfg); end
    endtask

    task automatic test_good_frame();
        frame_and_check("good_ffff", {16'hFFFF, 21'h0}, 1'b0, 1'b0);
    endtask

    task automatic test_bad_parity();
        frame_and_check("bad_par", {16'hFFFF, 21'h0}, 1'b1, 1'b0);
        frame_and_check("recover", {16'h1234, 21'h0A5A5}, 1'b0, 1'b0);
    endtask

    task automatic test_ce_gaps();
        frame_and_check("ce_gap", {16'hBEEF, 21'h15AC3}, 1'b0, 1'b1);
    endtask

    task automatic test_preamble_in_data();
        frame_and_check("pre_in_data", {16'h2222, 21'h02222}, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        frame_and_check("pre_bad", 37'h0ABCDE1234, 1'b1, 1'b0);
        send_frame(37'h1F0F0F0F0F, 1'b0, 1'b0, 20);
        n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b want 1", BUSY); end
        tick(1'b1, 1'b1, 1'b1);
        m_cfg = clb_default();
        m_err = 1'b0;
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", BUSY); end
        n_cmp++; if (CFG !== m_cfg) begin n_bad++; $display("FAIL mid_rst_cfg: got %h want %h", CFG, m_cfg); end
        n_cmp++; if (ERR !== 1'b0) begin n_bad++; $display("FAIL mid_rst_err: got %b want 0", ERR); end
        frame_and_check("after_rst", 37'h15A5A5A5A5, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            logic [36:0] d;
            d = {5'($urandom), $urandom};
            frame_and_check("rand", d, ($urandom_range(3, 0) == 0), ($urandom_range(1, 0) == 1));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_ce_gaps();
        test_preamble_in_data();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
